// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types and constants for the CPU memory-port arbiter and future bus masters.
// Wait counts are derived per address class; the counter width is sized by wait_cnt_width().
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } bus_state_e;

    typedef enum logic {
        OwnFetch,
        OwnData
    } bus_owner_e;

    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD003F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD003FC;
    localparam logic [4:0]  BYTEMODE_WORD  = 5'b01111;

    // Width holding the largest wait count, never narrower than one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned ram_wait,
                                                   input int unsigned uart_wait);
        int unsigned max_wait;
        max_wait = (ram_wait > uart_wait) ? ram_wait : uart_wait;
        return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response and MMU-side signals of the memory-port arbiter.
// slave is the arbiter's view; master is the pipeline-plus-MMU view.
interface mem_bus_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [4:0]  d_bytemode;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mmu_read;
    logic        mmu_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic [4:0]  mmu_bytemode;
    logic [31:0] mmu_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata, d_bytemode,
        output d_rdata, d_ready,
        output mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode,
        input  mmu_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata, d_bytemode,
        input  d_rdata, d_ready,
        input  mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode,
        output mmu_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_addr_class.sv
// Address classifier: maps a bus address to the number of extra cycles the
// MMU strobes must be held. Only the UART data register is slow.
module bus_addr_class
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT  = 0,
    parameter int unsigned UART_WAIT = 2,
    parameter int unsigned CntW      = wait_cnt_width(RAM_WAIT, UART_WAIT)
) (
    input  logic [31:0]     addr,
    output logic [CntW-1:0] wait_cnt
);

    always_comb begin
        wait_cnt = CntW'(RAM_WAIT);
        if (addr == UART_DATA_ADDR) begin
            wait_cnt = CntW'(UART_WAIT);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single MMU port: data beats fetch, each access is
// latched, held for a wait count, then completed with a one-cycle ready pulse.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT  = 0,
    parameter int unsigned UART_WAIT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_bus_arbiter_if.slave bus
);

    localparam int unsigned CntW = wait_cnt_width(RAM_WAIT, UART_WAIT);

    bus_state_e      state_q, state_d;
    bus_owner_e      owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      bytemode_q, bytemode_d;

    logic [31:0]     if_rdata_q, if_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            d_ready_q, d_ready_d;

    logic [31:0]     req_addr;
    logic [CntW-1:0] grant_wait;

    // Classify whichever address would win arbitration this cycle.
    assign req_addr = bus.d_req ? bus.d_addr : bus.if_addr;

    bus_addr_class #(
        .RAM_WAIT  (RAM_WAIT),
        .UART_WAIT (UART_WAIT),
        .CntW      (CntW)
    ) u_addr_class (
        .addr     (req_addr),
        .wait_cnt (grant_wait)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        read_d     = read_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bytemode_d = bytemode_q;
        if_rdata_d = if_rdata_q;
        if_ready_d = if_ready_q;
        d_rdata_d  = d_rdata_q;
        d_ready_d  = d_ready_q;

        unique case (state_q)
            StIdle: begin
                if (bus.d_req) begin
                    state_d    = StBusy;
                    owner_d    = OwnData;
                    cnt_d      = grant_wait;
                    addr_d     = bus.d_addr;
                    wdata_d    = bus.d_wdata;
                    bytemode_d = bus.d_bytemode;
                    read_d     = ~bus.d_we;
                    write_d    = bus.d_we;
                end else if (bus.if_req) begin
                    state_d    = StBusy;
                    owner_d    = OwnFetch;
                    cnt_d      = grant_wait;
                    addr_d     = bus.if_addr;
                    wdata_d    = '0;
                    bytemode_d = BYTEMODE_WORD;
                    read_d     = 1'b1;
                    write_d    = 1'b0;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (owner_q == OwnData) begin
                        // Stores return zero rather than whatever the MMU drives.
                        d_rdata_d = write_q ? 32'h0 : bus.mmu_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mmu_rdata;
                        if_ready_d = 1'b1;
                    end
                end
            end
            StDone: begin
                // Requests are not looked at here, so a held req cannot be re-granted.
                state_d    = StIdle;
                if_ready_d = 1'b0;
                d_ready_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= OwnFetch;
            cnt_q      <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bytemode_q <= '0;
            if_rdata_q <= '0;
            if_ready_q <= 1'b0;
            d_rdata_q  <= '0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bytemode_q <= bytemode_d;
            if_rdata_q <= if_rdata_d;
            if_ready_q <= if_ready_d;
            d_rdata_q  <= d_rdata_d;
            d_ready_q  <= d_ready_d;
        end
    end

    assign bus.mmu_read     = read_q;
    assign bus.mmu_write    = write_q;
    assign bus.mmu_addr     = addr_q;
    assign bus.mmu_wdata    = wdata_q;
    assign bus.mmu_bytemode = bytemode_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.if_ready     = if_ready_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.d_ready      = d_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a transaction-level model schedules
// grants by cycle arithmetic and queues expected MMU windows and ready pulses.
module tb_mem_bus_arbiter;

    localparam int unsigned RW = 0;
    localparam int unsigned UW = 2;
    localparam logic [31:0] UART_DATA = 32'hBFD003F8;
    localparam logic [31:0] UART_STAT = 32'hBFD003FC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .RAM_WAIT  (RW),
        .UART_WAIT (UW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory contents as a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    assign bus.mmu_rdata = mem_fn(bus.mmu_addr);

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    typedef struct {
        int          start;
        int          len;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  bm;
    } mmu_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } rdy_exp_t;

    mmu_exp_t mmu_q[$];
    rdy_exp_t if_q[$];
    rdy_exp_t d_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        mmu_exp_t e;
        logic     exp_r;
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (!rst_seen) begin
                check("reset_ctrl", {bus.mmu_read, bus.mmu_write, bus.if_ready, bus.d_ready,
                                     bus.mmu_bytemode}, '0);
                check("reset_data", {bus.mmu_addr, bus.mmu_wdata, bus.if_rdata, bus.d_rdata}, '0);
            end else begin
                if (mmu_q.size() > 0 && mmu_q[0].start <= cyc) begin
                    e = mmu_q[0];
                    check("mmu_fields", {bus.mmu_read, bus.mmu_write, bus.mmu_bytemode,
                                         bus.mmu_addr, bus.mmu_wdata},
                          {e.rd, e.wr, e.bm, e.addr, e.wdata});
                    if (cyc >= e.start + e.len - 1) void'(mmu_q.pop_front());
                end else begin
                    check("mmu_idle_strobes", {bus.mmu_read, bus.mmu_write}, 2'b00);
                end

                exp_r = (d_q.size() > 0 && d_q[0].cyc == cyc);
                check("d_ready", bus.d_ready, exp_r);
                if (exp_r) begin
                    check("d_rdata", bus.d_rdata, d_q[0].rdata);
                    void'(d_q.pop_front());
                end

                exp_r = (if_q.size() > 0 && if_q[0].cyc == cyc);
                check("if_ready", bus.if_ready, exp_r);
                if (exp_r) begin
                    check("if_rdata", bus.if_rdata, if_q[0].rdata);
                    void'(if_q.pop_front());
                end
            end
        end
    end

    // Requester + reference model state.
    bit d_pend = 0, d_granted = 0;
    bit if_pend = 0, if_granted = 0;
    int d_done = 0, if_done = 0;
    int idle_from = 0;

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return UART_DATA;
        if (sel == 1) return UART_STAT;
        return ($urandom & 32'h003F_FFFC) | 32'h8000_0000;
    endfunction

    task automatic new_data_req();
        bus.d_req      = 1'b1;
        bus.d_we       = 1'($urandom_range(0, 1));
        bus.d_addr     = rand_addr();
        bus.d_wdata    = $urandom;
        bus.d_bytemode = 5'($urandom_range(0, 31));
        d_pend         = 1;
        d_granted      = 0;
    endtask

    task automatic new_fetch_req();
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
        if_pend     = 1;
        if_granted  = 0;
    endtask

    // One model step, called at the falling edge of cycle k = cyc.
    task automatic stim_step(input bit allow_new);
        int k;
        int w;
        k = cyc;
        if (d_pend && d_granted && k == d_done) begin
            d_pend    = 0;
            bus.d_req = 1'b0;
        end
        if (if_pend && if_granted && k == if_done) begin
            if_pend    = 0;
            bus.if_req = 1'b0;
        end
        if (allow_new && !d_pend && $urandom_range(0, 2) == 0) new_data_req();
        if (allow_new && !if_pend && $urandom_range(0, 2) == 0) new_fetch_req();

        // Once granted, the fields must no longer matter.
        if (d_pend && d_granted) begin
            bus.d_we       = 1'($urandom_range(0, 1));
            bus.d_addr     = $urandom;
            bus.d_wdata    = $urandom;
            bus.d_bytemode = 5'($urandom_range(0, 31));
        end
        if (if_pend && if_granted) bus.if_addr = $urandom;

        if (rst_n && k >= idle_from) begin
            if (d_pend && !d_granted) begin
                w = (bus.d_addr == UART_DATA) ? UW : RW;
                mmu_q.push_back('{k + 1, w + 1, !bus.d_we, bus.d_we, bus.d_addr, bus.d_wdata,
                                  bus.d_bytemode});
                d_q.push_back('{k + w + 2, bus.d_we ? 32'h0 : mem_fn(bus.d_addr)});
                d_done    = k + w + 2;
                idle_from = k + w + 3;
                d_granted = 1;
            end else if (if_pend && !if_granted) begin
                w = (bus.if_addr == UART_DATA) ? UW : RW;
                mmu_q.push_back('{k + 1, w + 1, 1'b1, 1'b0, bus.if_addr, 32'h0, 5'b01111});
                if_q.push_back('{k + w + 2, mem_fn(bus.if_addr)});
                if_done    = k + w + 2;
                idle_from  = k + w + 3;
                if_granted = 1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (!d_pend && !if_pend && cyc >= idle_from) break;
            stim_step(1'b0);
            @(negedge clk);
        end
        check("drain_pending", {d_pend, if_pend}, 2'b00);
    endtask

    initial begin
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_bytemode = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests on the very first active cycle.
        new_data_req();
        new_fetch_req();
        for (int i = 0; i < 3000; i++) begin
            stim_step(1'b1);
            @(negedge clk);
        end
        drain();

        // UART load reset two cycles into its busy window, request held throughout.
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b0;
        bus.d_addr     = UART_DATA;
        bus.d_wdata    = 32'h41;
        bus.d_bytemode = 5'b00001;
        d_pend         = 1;
        d_granted      = 0;
        stim_step(1'b0);
        @(negedge clk);
        stim_step(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        mmu_q.delete();
        d_q.delete();
        if_q.delete();
        d_granted      = 0;
        idle_from      = cyc + 1;
        bus.d_we       = 1'b0;
        bus.d_addr     = UART_DATA;
        bus.d_wdata    = 32'h41;
        bus.d_bytemode = 5'b00001;
        stim_step(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        repeat (3) @(negedge clk);
        check("queues_empty", {32'(mmu_q.size()), 32'(d_q.size()), 32'(if_q.size())}, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory/peripheral port of the MMU between two requesters: instruction fetch (read-only) and the data/MEM stage (read/write with byte mode).
- Sequences each access as a registered transaction: latch the request, hold the MMU strobes for a configurable number of wait cycles, capture read data, then pulse a one-cycle ready to the winning requester.
- Sits between the CPU pipeline and the MMU; the pipeline stalls on outstanding requests.

Parameters:
- RAM_WAIT, 0, extra cycles strobes are held for SRAM accesses (total BUSY cycles = RAM_WAIT+1).
- UART_WAIT, 2, extra cycles strobes are held for accesses to UART data address 32'hBFD003F8.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held with fields until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_bytemode  in  5  MMU byte mode: bit4 = zero-extend, [3:0] = lane enables.
- d_rdata  out  32  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mmu_read  out  1  to MMU if_read.
- mmu_write  out  1  to MMU if_write.
- mmu_addr  out  32  to MMU addr.
- mmu_wdata  out  32  to MMU input_data.
- mmu_bytemode  out  5  to MMU bytemode.
- mmu_rdata  in  32  from MMU output_data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, cnt=0, owner=FETCH; all outputs 0. The reset value of mmu_bytemode is 5'b00000.
- Registered outputs: all mmu_* outputs are registered from latched request fields. They are never combinational from the requester inputs.

FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If d_req=1, grant data (data has absolute priority over fetch).
  - Else if if_req=1, grant fetch.
  - On grant at edge N: latch addr/wdata/bytemode/we and owner, and load cnt with UART_WAIT if addr==32'hBFD003F8, else RAM_WAIT.
  - Drive mmu_read = ~we (fetch: always read) and mmu_write = we (fetch: 0). Go to BUSY.
  - mmu_read=mmu_write=0 while in IDLE.
- BUSY:
  - mmu strobes and fields are held constant; requester inputs are ignored.
  - If cnt≠0: cnt ← cnt−1.
  - If cnt==0 at an edge: capture mmu_rdata into the owner's rdata register (stores capture 0), clear mmu_read and mmu_write, set the owner's ready, and go to DONE.
- DONE:
  - Exactly one cycle with the owner's ready=1; the other ready=0.
  - Requests are ignored in this cycle, so a still-high req is not re-granted.
  - Next edge: ready←0, go to IDLE.
- Latency: request seen in IDLE at cycle 0 → ready high in cycle RAM_WAIT+2. Back-to-back throughput is one access per WAIT+3 cycles.
- Fetch fields (fetch grant):
  - mmu_bytemode = 5'b01111 and mmu_wdata = 0.
  - mmu_addr is not cleared in IDLE/DONE; it holds its last value.
- rdata hold: if_rdata and d_rdata hold their last captured value until overwritten.
- Simultaneous requests: data wins. Fetch remains pending and is granted in the first IDLE cycle with d_req=0.
- Starvation: fetch may be starved indefinitely by continuous d_req.
- Reset mid-transaction: the next edge with rst_n=0 returns to IDLE with strobes low. No ready is issued and the transaction is dropped; requesters must reissue.
- UART status reads (32'hBFD003FC) use RAM_WAIT.
- Width rules: cnt width = clog2(max(RAM_WAIT, UART_WAIT)+1), minimum 1 bit. No arithmetic is performed on addresses.

Decomposition:
- Shared package (cpu_bus_pkg): state enum {IDLE, BUSY, DONE}; owner enum {FETCH, DATA}; constants UART_DATA_ADDR=32'hBFD003F8 and UART_STAT_ADDR=32'hBFD003FC; BYTEMODE_WORD=5'b01111.
- Sub-module bus_addr_class: combinational; maps an address to its wait count. It is reused by a future cache or DMA master.

Test Plan:
- Single fetch, RAM_WAIT=0: if_req=1, if_addr=32'h80000000, mmu_rdata=32'h3C1D8040 → mmu_read=1 in cycle 1 only; if_ready=1 and if_rdata=32'h3C1D8040 in cycle 2; d_ready=0 throughout.
- Simultaneous requests: if_req=1 and d_req=1 (load, d_addr=32'h80400004, bytemode 5'b00001) in the same cycle → data served first (d_ready cycle 2), fetch granted cycle 3, if_ready cycle 5.
- UART write, UART_WAIT=2: d_we=1, d_addr=32'hBFD003F8, d_wdata=32'h41 → mmu_write=1 for exactly 3 cycles with mmu_wdata=32'h41; d_ready in cycle 4; d_rdata=0.
- Held request: d_req kept high through DONE → no second grant from DONE; re-grant occurs only from the next IDLE cycle. Exactly one d_ready per grant.
- Reset mid-BUSY with UART_WAIT=2: rst_n=0 in cycle 2 → next edge state=IDLE, mmu_read=mmu_write=0, no ready pulse; with rst_n=1 and req still high, a fresh grant follows.
- Stability: change d_addr while BUSY → mmu_addr stays at the latched value until DONE.
